// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
//
// Sequences the shared fetch/decode/LSU/ALU pipeline across NUM_WARPS warp
// contexts with exactly one warp in flight at a time. Each warp has its own PC
// and done flag. After every retired instruction the next ready warp is picked
// round-robin, starting just after the warp that retired.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   start, start_pc,                kernel launch pulse, entry PC and the set
//   active_warp_mask                of participating warps (sampled on start)
//   fetch_req, fetch_pc             instruction fetch handshake towards fetcher
//   fetch_ready                     fetched instruction valid
//   warp_state, current_warp        pipeline phase and warp in flight
//   decoded_halt, decoded_mem_*     decoder outputs, valid from REQUEST onward
//   lsu_done                        memory access complete
//   branch_taken, branch_target     ALU branch resolution
//   done                            every participating warp has halted
// -----------------------------------------------------------------------------
package warp_scheduler_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;
endpackage

module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int PC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PC_WIDTH-1:0]          start_pc,
    input  logic [NUM_WARPS-1:0]         active_warp_mask,
    output logic                         fetch_req,
    output logic [PC_WIDTH-1:0]          fetch_pc,
    input  logic                         fetch_ready,
    output warp_state_t                  warp_state,
    output logic [$clog2(NUM_WARPS)-1:0] current_warp,
    input  logic                         decoded_halt,
    input  logic                         decoded_mem_read_enable,
    input  logic                         decoded_mem_write_enable,
    input  logic                         lsu_done,
    input  logic                         branch_taken,
    input  logic [PC_WIDTH-1:0]          branch_target,
    output logic                         done
);

    localparam int CW = $clog2(NUM_WARPS);

    warp_state_t           r_state;
    warp_state_t           w_state_nxt;
    logic [CW-1:0]         r_cur;
    logic [PC_WIDTH-1:0]   r_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]  r_warp_done;
    logic                  r_br_taken;
    logic [PC_WIDTH-1:0]   r_br_target;

    logic                  w_launch;
    logic [CW-1:0]         w_first;
    logic                  w_first_found;
    logic [CW-1:0]         w_cand;
    logic [CW-1:0]         w_next;
    logic                  w_next_found;
    logic                  w_mem_access;

    // A launch is only honoured when no kernel is running.
    assign w_launch = start && ((r_state == WARP_IDLE) || (r_state == WARP_DONE));

    assign w_mem_access = decoded_mem_read_enable || decoded_mem_write_enable;

    // Lowest participating warp; scanning downward lets the lowest index win.
    always_comb begin
        w_first       = '0;
        w_first_found = 1'b0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (active_warp_mask[i]) begin
                w_first       = CW'(i);
                w_first_found = 1'b1;
            end
        end
    end

    // Round-robin pick: offsets NUM_WARPS..1 scanned downward so the smallest
    // offset wins. Offset NUM_WARPS truncates to 0, i.e. the current warp is
    // the last candidate. r_warp_done already reflects a halt set in REQUEST.
    always_comb begin
        w_cand       = '0;
        w_next       = r_cur;
        w_next_found = 1'b0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            w_cand = r_cur + CW'(k);
            if (!r_warp_done[w_cand]) begin
                w_next       = w_cand;
                w_next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WARP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WARP_IDLE, WARP_DONE: begin
                if (start) begin
                    w_state_nxt = w_first_found ? WARP_FETCH : WARP_DONE;
                end
            end
            WARP_FETCH: begin
                if (fetch_ready) begin
                    w_state_nxt = WARP_DECODE;
                end
            end
            WARP_DECODE:  w_state_nxt = WARP_REQUEST;
            WARP_REQUEST: w_state_nxt = decoded_halt ? WARP_UPDATE : WARP_WAIT;
            WARP_WAIT: begin
                // Non-memory instructions pass through WAIT in one cycle.
                if (!w_mem_access || lsu_done) begin
                    w_state_nxt = WARP_EXECUTE;
                end
            end
            WARP_EXECUTE: w_state_nxt = WARP_UPDATE;
            WARP_UPDATE:  w_state_nxt = w_next_found ? WARP_FETCH : WARP_DONE;
            default:      w_state_nxt = WARP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i] <= '0;
            end
            r_warp_done <= '1;
            r_cur       <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            if (w_launch) begin
                for (int i = 0; i < NUM_WARPS; i++) begin
                    r_pc[i] <= start_pc;
                end
                r_warp_done <= ~active_warp_mask;
                r_cur       <= w_first;
            end
            if ((r_state == WARP_REQUEST) && decoded_halt) begin
                r_warp_done[r_cur] <= 1'b1;
            end
            if (r_state == WARP_EXECUTE) begin
                r_br_taken  <= branch_taken;
                r_br_target <= branch_target;
            end
            if (r_state == WARP_UPDATE) begin
                // A halted warp keeps the PC of its halt instruction.
                if (!r_warp_done[r_cur]) begin
                    r_pc[r_cur] <= r_br_taken ? r_br_target
                                              : r_pc[r_cur] + PC_WIDTH'(4);
                end
                if (w_next_found) begin
                    r_cur <= w_next;
                end
            end
        end
    end

    assign warp_state   = r_state;
    assign current_warp = r_cur;
    assign fetch_req    = (r_state == WARP_FETCH);
    assign fetch_pc     = r_pc[r_cur];
    assign done         = (r_state == WARP_DONE);

endmodule

// File: tb/tb_warp_scheduler.sv
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_pc;
    logic [3:0]  active_warp_mask;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    warp_state_t warp_state;
    logic [1:0]  current_warp;
    logic        decoded_halt;
    logic        decoded_mem_read_enable;
    logic        decoded_mem_write_enable;
    logic        lsu_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        done;

    warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(32)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .start_pc                 (start_pc),
        .active_warp_mask         (active_warp_mask),
        .fetch_req                (fetch_req),
        .fetch_pc                 (fetch_pc),
        .fetch_ready              (fetch_ready),
        .warp_state               (warp_state),
        .current_warp             (current_warp),
        .decoded_halt             (decoded_halt),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .lsu_done                 (lsu_done),
        .branch_taken             (branch_taken),
        .branch_target            (branch_target),
        .done                     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  warp;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model of the warp contexts.
    logic [31:0] m_pc [4];
    logic [3:0]  m_done;
    logic [1:0]  m_cur;

    logic [1:0]  last_warp;
    logic [31:0] last_pc;
    int          last_wait;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.warp = m_cur;
        e.pc   = m_pc[m_cur];
        sb_q.push_back(e);
    endtask

    task automatic launch(input logic [3:0] mask, input logic [31:0] pc);
        active_warp_mask = mask;
        start_pc         = pc;
        start            = 1'b1;
        tick();
        start            = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_pc[i]   = pc;
            m_done[i] = ~mask[i];
        end
        m_cur = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) m_cur = 2'(i);
        end
        if (mask != 4'b0000) push_exp();
    endtask

    task automatic m_retire(input logic halt, input logic br, input logic [31:0] tgt);
        logic       found;
        logic [1:0] idx;
        if (halt) m_done[m_cur] = 1'b1;
        else      m_pc[m_cur]   = br ? tgt : m_pc[m_cur] + 32'd4;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(int'(m_cur) + k);
            if (!found && !m_done[idx]) begin
                found = 1'b1;
                m_cur = idx;
            end
        end
        if (found) push_exp();
    endtask

    // Plays fetcher/decoder/LSU/ALU for one instruction, starting in FETCH.
    task automatic run_instr(input logic halt, input logic mem, input int fstall,
                             input int lstall, input logic br, input logic [31:0] tgt,
                             input logic poke_start, input int exp_lat);
        exp_t        e;
        int          cyc;
        int          fcnt;
        int          wcnt;
        warp_state_t s;
        cyc  = 0;
        fcnt = 0;
        wcnt = 0;
        chk("in_fetch", 64'(warp_state), 64'(WARP_FETCH));
        chk("fetch_req", 64'(fetch_req), 64'd1);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk("warp", 64'(current_warp), 64'(e.warp));
            chk("fetch_pc", 64'(fetch_pc), 64'(e.pc));
        end
        last_warp = current_warp;
        last_pc   = fetch_pc;
        for (int it = 0; it < 64; it++) begin
            s     = warp_state;
            start = 1'b0;
            case (s)
                WARP_FETCH: begin
                    fetch_ready = (fcnt >= fstall);
                    if (poke_start && fcnt == 0) begin
                        start            = 1'b1;
                        start_pc         = 32'hDEAD_0000;
                        active_warp_mask = 4'b0100;
                    end
                    fcnt++;
                end
                WARP_DECODE: begin
                    fetch_ready             = 1'b0;
                    decoded_halt            = halt;
                    decoded_mem_read_enable = mem;
                end
                WARP_WAIT: begin
                    lsu_done = (wcnt >= lstall);
                    wcnt++;
                end
                WARP_EXECUTE: begin
                    lsu_done      = 1'b0;
                    branch_taken  = br;
                    branch_target = tgt;
                end
                WARP_UPDATE: branch_taken = 1'b0;
                default: ;
            endcase
            tick();
            cyc++;
            if (s == WARP_UPDATE) break;
        end
        start                   = 1'b0;
        fetch_ready             = 1'b0;
        decoded_halt            = 1'b0;
        decoded_mem_read_enable = 1'b0;
        lsu_done                = 1'b0;
        branch_taken            = 1'b0;
        chk("latency", 64'(cyc), 64'(exp_lat));
        last_wait = wcnt;
        m_retire(halt, br, tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rr_exp [6];
        rr_exp = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        reset                    = 1'b1;
        start                    = 1'b0;
        start_pc                 = 32'h0;
        active_warp_mask         = 4'b0;
        fetch_ready              = 1'b0;
        decoded_halt             = 1'b0;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        lsu_done                 = 1'b0;
        branch_taken             = 1'b0;
        branch_target            = 32'h0;
        #1;
        chk("rst_state", 64'(warp_state), 64'(WARP_IDLE));
        chk("rst_cur", 64'(current_warp), 64'd0);
        chk("rst_fetch_req", 64'(fetch_req), 64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Empty mask goes straight to DONE.
        launch(4'b0000, 32'h50);
        chk("mask0_state", 64'(warp_state), 64'(WARP_DONE));
        chk("mask0_done", 64'(done), 64'd1);

        // Single warp: three plain instructions then a halt.
        launch(4'b0001, 32'h100);
        chk("sw_state", 64'(warp_state), 64'(WARP_FETCH));
        chk("sw_done_clr", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
            chk("sw_pc_seq", 64'(last_pc), 64'(32'h100 + 32'(4 * i)));
        end
        run_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 4);
        chk("sw_halt_pc", 64'(last_pc), 64'h10C);
        chk("sw_end_state", 64'(warp_state), 64'(WARP_DONE));
        chk("sw_end_done", 64'(done), 64'd1);

        // Round-robin over warps 0,1,3; a start pulse during a stalled FETCH
        // of the second instruction must be ignored.
        launch(4'b1011, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) run_instr(1'b0, 1'b0, 2, 0, 1'b0, 32'h0, 1'b1, 8);
            else        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
            chk("rr_order", 64'(last_warp), 64'(rr_exp[i]));
        end

        // Branch on warp 1, then a load with a 5-cycle LSU stall.
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        run_instr(1'b0, 1'b0, 0, 0, 1'b1, 32'h200, 1'b0, 6);
        chk("br_warp", 64'(last_warp), 64'd1);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        chk("br_other_pc", 64'(last_pc), 64'h8);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        chk("br_w0_pc", 64'(last_pc), 64'hC);
        run_instr(1'b0, 1'b1, 0, 5, 1'b0, 32'h0, 1'b0, 11);
        chk("br_target_pc", 64'(last_pc), 64'h200);
        chk("mem_wait_cycles", 64'(last_wait), 64'd6);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        run_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 4);
        chk("mem_pc_adv", 64'(last_pc), 64'h204);
        run_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 4);
        run_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 4);
        chk("rr_end_state", 64'(warp_state), 64'(WARP_DONE));
        chk("rr_end_done", 64'(done), 64'd1);

        // Reset during WAIT of warp 2.
        launch(4'b0111, 32'h300);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rst_mid_warp", 64'(current_warp), 64'(e.warp));
            chk("rst_mid_pc", 64'(fetch_pc), 64'(e.pc));
        end
        fetch_ready = 1'b1;
        tick();
        fetch_ready             = 1'b0;
        decoded_mem_read_enable = 1'b1;
        tick();
        tick();
        chk("rst_mid_in_wait", 64'(warp_state), 64'(WARP_WAIT));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_state", 64'(warp_state), 64'(WARP_IDLE));
        chk("rst_async_freq", 64'(fetch_req), 64'd0);
        chk("rst_async_cur", 64'(current_warp), 64'd0);
        chk("rst_async_pc", 64'(fetch_pc), 64'd0);
        decoded_mem_read_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        launch(4'b0001, 32'h400);
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 6);
        chk("post_rst_pc", 64'(last_pc), 64'h400);
        run_instr(1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 4);
        chk("post_rst_done", 64'(done), 64'd1);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Sequences the shared lock-in execution pipeline (fetcher, decoder, LSU, ALU) across up to NUM_WARPS warps, one warp in flight at a time. It holds a per-warp PC and done flag. It drives the `warp_state` that gates the decoder and the other stages, and it selects the next ready warp round-robin after each instruction retires. It sits at the top of the compute core, between kernel launch control and the per-stage datapath.

## Interface
- NUM_WARPS, 4: number of warp contexts; power of two, 2–16.
- PC_WIDTH, 32: program-counter width; PC increments by 4.

- clk  in  1  core clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  kernel launch pulse; honoured only in WARP_IDLE or WARP_DONE.
- start_pc  in  PC_WIDTH  entry PC loaded into every warp on start.
- active_warp_mask  in  NUM_WARPS  warps taking part in the launch; sampled on start.
- fetch_req  out  1  high throughout WARP_FETCH.
- fetch_pc  out  PC_WIDTH  PC of current_warp; stable while fetch_req is high.
- fetch_ready  in  1  instruction is valid; sampled only in WARP_FETCH.
- warp_state  out  warp_state_t  current pipeline phase (states listed below).
- current_warp  out  $clog2(NUM_WARPS)  index of the warp in flight.
- decoded_halt, decoded_mem_read_enable, decoded_mem_write_enable  in  1 each  from the decoder; valid from WARP_REQUEST onward.
- lsu_done  in  1  memory access complete; sampled only in WARP_WAIT.
- branch_taken  in  1  from the ALU; sampled only in WARP_EXECUTE.
- branch_target  in  PC_WIDTH  new PC when branch_taken is high.
- done  out  1  all participating warps have halted.

## Operation
- States: WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE.
- IDLE or DONE with start=1:
  - pc[i] <= start_pc for every warp.
  - warp_done[i] <= ~active_warp_mask[i].
  - current_warp <= lowest set bit of the mask; next state FETCH.
  - If the mask is all-zero, next state DONE.
  - done clears on leaving DONE.
- FETCH: hold fetch_req=1 until fetch_ready=1, then go to DECODE.
- DECODE: 1 cycle. The decoder registers its outputs on this edge.
- REQUEST: 1 cycle.
  - If decoded_halt=1: set warp_done[current_warp], go to UPDATE, and leave the PC unchanged.
  - Otherwise go to WAIT.
- WAIT:
  - If neither mem enable is set, leave after 1 cycle.
  - If either mem enable is set, stay until lsu_done=1.
  - Then go to EXECUTE.
- EXECUTE: 1 cycle. Latch branch_taken and branch_target.
- UPDATE: 1 cycle.
  - Non-halted warp: pc <= branch_taken ? branch_target : pc + 4, wrapping mod 2^PC_WIDTH.
  - Select the next warp round-robin: search from current_warp+1 upward, wrapping, for the first warp with warp_done=0. The search includes current_warp last.
  - A warp is found: load it into current_warp and go to FETCH.
  - No warp is found: go to DONE.
- DONE: done=1; hold until start.
- start outside IDLE/DONE: ignored.
- fetch_ready outside FETCH and lsu_done outside WAIT: ignored.

## Timing
- Reset values:
  - warp_state = WARP_IDLE, current_warp = 0.
  - fetch_req = 0, fetch_pc = 0, done = 0.
  - All pc = 0, all warp_done = 1.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- Minimum instruction latency, with fetch_ready and lsu_done high on first sampling: 6 cycles (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
  - Each extra fetch stall cycle adds 1 cycle.
  - Each extra LSU stall cycle adds 1 cycle.
- Halt instruction latency: 4 cycles (FETCH, DECODE, REQUEST, UPDATE).
- start -> FETCH: next cycle. Last halt in UPDATE -> done=1: next cycle.
- Reset asserted mid-instruction returns everything to reset values asynchronously. No partial PC update survives.

## Test plan
- Single warp:
  - Stimulus: mask=4'b0001, start_pc=0x100, three non-mem, non-branch instructions then a halt, fetch_ready tied high.
  - Required: fetch_pc sequence 0x100, 0x104, 0x108, 0x10C. Each non-halt instruction takes 6 cycles. done=1 on the cycle after the halt's UPDATE.
- Round-robin:
  - Stimulus: mask=4'b1011, all warps executing non-mem instructions.
  - Required: current_warp order 0, 1, 3, 0, 1, 3. Warp 2 is never selected.
- Memory stall:
  - Stimulus: a load instruction with lsu_done held low for 5 WAIT cycles.
  - Required: warp_state stays WARP_WAIT for 6 cycles. Total instruction latency is 11 cycles. The PC advances by 4.
- Branch:
  - Stimulus: branch_taken=1, branch_target=0x200 in EXECUTE for warp 1.
  - Required: pc[1]=0x200 on warp 1's next fetch_pc. Other warps' PCs are unchanged.
- Launch boundaries:
  - Stimulus: start with mask=0; then start pulsed while in FETCH.
  - Required: mask=0 gives DONE on the next cycle with done=1. The start pulsed in FETCH has no effect on PCs or state.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT of warp 2.
  - Required: warp_state becomes WARP_IDLE and fetch_req becomes 0 without waiting for a clock edge. After release, a new start runs normally from start_pc.
